// File: rtl/bip_pkg.sv
// Shared encodings for the accumulator-processor control unit: opcodes,
// FSM states, datapath select codes and the decoded control word.
package bip_pkg;

  localparam int unsigned OPCODE_WIDTH  = 5;
  localparam int unsigned OPERAND_WIDTH = 11;
  localparam int unsigned DATA_WIDTH    = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_e;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic       SEL_B_RAM = 1'b0;
  localparam logic       SEL_B_IMM = 1'b1;
  localparam logic       ALU_ADD   = 1'b0;
  localparam logic       ALU_SUB   = 1'b1;

  typedef struct packed {
    logic       mem_op;
    logic       imm_op;
    logic       acc_we;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       ram_wr;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode decoder producing the state-independent control word.
module bip_decoder
  import bip_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output ctrl_t                   ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HLT: ctrl.illegal = 1'b0;
      OP_STO: ctrl.ram_wr = 1'b1;
      OP_LDI: begin
        ctrl.imm_op = 1'b1;
        ctrl.acc_we = 1'b1;
        ctrl.sel_a  = SEL_A_IMM;
      end
      OP_ADDI, OP_SUBI: begin
        ctrl.imm_op = 1'b1;
        ctrl.acc_we = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = SEL_B_IMM;
        ctrl.alu_op = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      OP_LD: begin
        ctrl.mem_op = 1'b1;
        ctrl.acc_we = 1'b1;
        ctrl.sel_a  = SEL_A_RAM;
      end
      OP_ADD, OP_SUB: begin
        ctrl.mem_op = 1'b1;
        ctrl.acc_we = 1'b1;
        ctrl.sel_a  = SEL_A_ALU;
        ctrl.sel_b  = SEL_B_RAM;
        ctrl.alu_op = (opcode == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/bip_acc_ctrl.sv
// Accumulator-processor control FSM (IDLE/FETCH/EXEC/MEM/HALT).
// Define BIP_ILLEGAL_TRAP_EN to halt and raise trap on undefined opcodes.
module bip_acc_ctrl
  import bip_pkg::*;
#(
  parameter int unsigned OPCODE_W  = OPCODE_WIDTH,
  parameter int unsigned OPERAND_W = OPERAND_WIDTH,
  parameter int unsigned DATA_W    = DATA_WIDTH,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    instr,
  output logic                 pc_en,
  output logic                 acc_en,
  output logic [1:0]           sel_a,
  output logic                 sel_b,
  output logic                 alu_op,
  output logic                 ram_rd,
  output logic                 ram_wr,
  output logic [OPERAND_W-1:0] operand,
  output logic                 busy,
  output logic                 halted,
  output logic                 trap,
  output logic [CNT_W-1:0]     cycle_cnt
);

`ifdef BIP_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                trap_q, trap_d;
  ctrl_t               dec;
  logic                is_hlt;
  logic                trap_stop;

  bip_decoder u_dec (
    .opcode (ir_q[DATA_W-1 -: OPCODE_W]),
    .ctrl   (dec)
  );

  assign is_hlt    = (ir_q[DATA_W-1 -: OPCODE_W] == OP_HLT);
  assign trap_stop = TRAP_EN & dec.illegal;
  assign operand   = ir_q[OPERAND_W-1:0];
  assign cycle_cnt = cnt_q;
  assign trap      = trap_q;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    trap_d  = trap_q;
    pc_en   = 1'b0;
    acc_en  = 1'b0;
    sel_a   = SEL_A_RAM;
    sel_b   = SEL_B_RAM;
    alu_op  = ALU_ADD;
    ram_rd  = 1'b0;
    ram_wr  = 1'b0;
    busy    = state_q inside {ST_FETCH, ST_EXEC, ST_MEM};
    halted  = (state_q == ST_HALT);

    if (busy && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        ir_d    = instr;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_hlt || trap_stop) begin
          state_d = ST_HALT;
          trap_d  = trap_q | trap_stop;
        end else if (dec.mem_op) begin
          ram_rd  = 1'b1;
          state_d = ST_MEM;
        end else begin
          // Immediate ops, STO and NOP-like opcodes retire here.
          pc_en   = 1'b1;
          ram_wr  = dec.ram_wr;
          acc_en  = dec.acc_we & dec.imm_op;
          sel_a   = dec.sel_a;
          sel_b   = dec.sel_b;
          alu_op  = dec.alu_op;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        acc_en  = dec.acc_we;
        pc_en   = 1'b1;
        sel_a   = dec.sel_a;
        sel_b   = dec.sel_b;
        alu_op  = dec.alu_op;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase

    // Reset drops any pending write and leaves the PC untouched.
    if (!rst_n) begin
      pc_en  = 1'b0;
      acc_en = 1'b0;
      ram_rd = 1'b0;
      ram_wr = 1'b0;
      sel_a  = SEL_A_RAM;
      sel_b  = SEL_B_RAM;
      alu_op = ALU_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: doc/bip_acc_ctrl.md
Name: bip_acc_ctrl

Overview:
- Control unit that sequences the 16-bit accumulator datapath (acc, ALU, operand muxes, data RAM) of the accumulator processor.
- Fetches 16-bit instructions from program memory and decodes them into a 5-bit opcode and an 11-bit operand.
- Drives the accumulator `enable`, the mux selects, the ALU op, the RAM strobes and the PC advance through a small FSM.
- Sits between program memory / PC and the acc/ALU/RAM datapath.

Parameters:
- OPCODE_W, 5, opcode field width (instr[15:11]).
- OPERAND_W, 11, operand/address field width (instr[10:0]).
- DATA_W, 16, instruction and datapath width.
- CNT_W, 16, width of the cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin execution; sampled only in IDLE.
- instr  in  DATA_W  program-memory read data, valid one cycle after the PC changes.
- pc_en  out  1  advance PC by 1 at the next edge.
- acc_en  out  1  accumulator load enable (drives acc `enable`).
- sel_a  out  2  acc input mux: 0 RAM data, 1 sign-extended operand, 2 ALU result.
- sel_b  out  1  ALU B operand: 0 RAM data, 1 sign-extended operand.
- alu_op  out  1  0 add, 1 subtract.
- ram_rd  out  1  data-RAM read strobe; data valid the next cycle.
- ram_wr  out  1  data-RAM write strobe (writes acc to address `operand`).
- operand  out  OPERAND_W  operand field of the latched instruction register (ir).
- busy  out  1  high in FETCH, EXEC and MEM.
- halted  out  1  high in HALT.
- trap  out  1  illegal-opcode trap flag; see Optional Feature.
- cycle_cnt  out  CNT_W  count of executed cycles.

Behaviour:
- States: IDLE, FETCH, EXEC, MEM, HALT. Reset puts the FSM in IDLE with ir=0, cycle_cnt=0 and trap=0.
- While rst_n=0, all strobes (pc_en, acc_en, ram_rd, ram_wr) and the selects are forced to 0 combinationally.
- IDLE: start=1 moves to FETCH and clears cycle_cnt. start is ignored in every other state.
- FETCH: 1 cycle. The memory read completes; ir<=instr at the end of the cycle. Next state EXEC.
- EXEC, decoding ir[15:11]:
  - 00000 HLT: go to HALT; pc_en=0.
  - 00001 STO: ram_wr=1; pc_en=1; go to FETCH.
  - 00011 LDI: acc_en=1, sel_a=1; pc_en=1; go to FETCH.
  - 00101 ADDI / 00111 SUBI: acc_en=1, sel_a=2, sel_b=1, alu_op=0/1; pc_en=1; go to FETCH.
  - 00010 LD, 00100 ADD, 00110 SUB: ram_rd=1; go to MEM.
  - Any other opcode: NOP; pc_en=1; go to FETCH.
- MEM: acc_en=1 and pc_en=1, then go to FETCH.
  - LD: sel_a=0.
  - ADD: sel_a=2, sel_b=0, alu_op=0.
  - SUB: sel_a=2, sel_b=0, alu_op=1.
- Latency: immediate ops, STO and NOP take 2 cycles; memory ops take 3 cycles.
- HALT: terminal. All strobes 0; halted=1. Only rst_n=0 leaves it (to IDLE).
- Outputs are combinational from the registered state and ir. Every strobe is a single-cycle pulse. Selects are 0 whenever they are not in use.
- operand = ir[10:0] in every state. Sign extension of the operand happens in the datapath, not in this block.
- cycle_cnt increments each cycle busy=1 and saturates at all-ones (no wrap).
- Reset in EXEC or MEM: the pending acc/RAM write is dropped. The next state is IDLE and the PC is untouched by this block.

Optional Feature:
- Macro: BIP_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in EXEC goes to HALT with pc_en=0. trap is set and held until reset.
- Undefined: an undefined opcode executes as a NOP as described above, and trap is tied to 0.

Decomposition:
- Shared package bip_pkg holds:
  - the opcode localparams (HLT, STO, LD, LDI, ADD, ADDI, SUB, SUBI);
  - the state encoding;
  - the sel_a/sel_b/alu_op encodings;
  - the field widths.
- One sub-module, bip_decoder: combinational opcode -> {mem_op, imm_op, acc_we, sel_a, sel_b, alu_op, ram_wr, illegal}. The FSM in bip_acc_ctrl gates this control word by state.

Test Plan:
1. Program 0x1803, 0x2807, 0x0805, 0x0000 (LDI 3; ADDI 7; STO 5; HLT), then a start pulse.
   - acc_en pulses with sel_a=1, then sel_a=2/sel_b=1/alu_op=0.
   - ram_wr pulses with operand=5.
   - halted=1 after 8 busy cycles; cycle_cnt=8.
2. Instruction 0x1005 (LD 5): ram_rd=1 with operand=5 in EXEC; in the next cycle acc_en=1, sel_a=0, pc_en=1. 3-cycle instruction.
3. Instruction 0x3002 (SUB 2): ram_rd in EXEC; in MEM acc_en=1, sel_a=2, sel_b=0, alu_op=1.
4. Instruction 0xF800 (illegal):
   - without the macro: pc_en=1 with no other strobe, and execution continues;
   - with BIP_ILLEGAL_TRAP_EN: halted=1, trap=1, pc_en=0.
5. rst_n=0 during the MEM cycle of LD: no acc_en pulse, state returns to IDLE, cycle_cnt=0. Holding start=1 afterwards restarts from FETCH.
6. start pulsed while busy and while in HALT: no effect. With cycle_cnt preset near saturation via a long NOP loop (CNT_W=4), cycle_cnt holds at 15.
